// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared types and constants for the 4x4 keypad scanner
// Scanner states, {row,col}-indexed key map and row priority helper.
package keypad_pkg;

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_HELD     = 2'd2,
    ST_RELEASE  = 2'd3
  } scan_state_e;

  localparam logic [3:0] KEY_STAR = 4'hE;
  localparam logic [3:0] KEY_HASH = 4'hF;

  // Element {row,col}; the last item of the concatenation is entry 0 (r0/c0 = '1').
  localparam logic [15:0][3:0] KEYMAP = {
    4'hD, KEY_HASH, 4'h0, KEY_STAR,
    4'hC, 4'h9,     4'h8, 4'h7,
    4'hB, 4'h6,     4'h5, 4'h4,
    4'hA, 4'h3,     4'h2, 4'h1
  };

  function automatic logic [1:0] lowest_low_row(input logic [3:0] rows);
    if (!rows[0])      return 2'd0;
    else if (!rows[1]) return 2'd1;
    else if (!rows[2]) return 2'd2;
    else               return 2'd3;
  endfunction

endpackage

// File: rtl/keypad_scan_tick_gen.sv
// rtl/keypad_scan_tick_gen.sv - free-running divider producing a one-clk scan tick
// Tick is high for the single cycle in which the divider is about to wrap.
module scan_tick_gen #(
  parameter int SCAN_DIV = 17
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  logic [SCAN_DIV-1:0] div_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) div_q <= '0;
    else        div_q <= div_q + {{(SCAN_DIV-1){1'b0}}, 1'b1};
  end

  assign tick = &div_q;

endmodule

// File: rtl/keypad_scan.sv
// rtl/keypad_scan.sv - 4x4 matrix keypad scanner with press/release debounce
// Optional KEYPAD_BCD_ACCUM_EN adds a three-digit BCD entry accumulator.
module keypad_scan import keypad_pkg::*; #(
  parameter int SCAN_DIV       = 17,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [3:0] key_row,
  output logic [3:0] key_col,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
`ifdef KEYPAD_BCD_ACCUM_EN
  ,
  output logic [3:0] bcd2,
  output logic [3:0] bcd1,
  output logic [3:0] bcd0
`endif
);

  localparam logic [4:0] DB_SCANS = 5'(DEBOUNCE_SCANS);

  logic        tick;
  logic [3:0]  row_s1_q, row_s2_q;
  scan_state_e state_q, state_d;
  logic [1:0]  col_idx_q, col_idx_d;
  logic [1:0]  row_q, row_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  code_q, code_d;
  logic        valid_q, valid_d;
  logic        pressed;
  logic [1:0]  low_row;
  logic [4:0]  cnt_inc;

  scan_tick_gen #(.SCAN_DIV(SCAN_DIV)) u_tick (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      row_s1_q  <= 4'hF;
      row_s2_q  <= 4'hF;
      state_q   <= ST_SCAN;
      col_idx_q <= 2'd0;
      row_q     <= 2'd0;
      cnt_q     <= 4'd0;
      code_q    <= 4'd0;
      valid_q   <= 1'b0;
    end else begin
      row_s1_q  <= key_row;
      row_s2_q  <= row_s1_q;
      state_q   <= state_d;
      col_idx_q <= col_idx_d;
      row_q     <= row_d;
      cnt_q     <= cnt_d;
      code_q    <= code_d;
      valid_q   <= valid_d;
    end
  end

  assign pressed = ~&row_s2_q;
  assign low_row = lowest_low_row(row_s2_q);
  assign cnt_inc = {1'b0, cnt_q} + 5'd1;

  always_comb begin
    state_d   = state_q;
    col_idx_d = col_idx_q;
    row_d     = row_q;
    cnt_d     = cnt_q;
    code_d    = code_q;
    valid_d   = 1'b0;
    if (!enable) begin
      state_d = ST_SCAN;
      cnt_d   = 4'd0;
    end else if (tick) begin
      case (state_q)
        ST_SCAN: begin
          if (pressed) begin
            row_d   = low_row;
            cnt_d   = 4'd1;
            state_d = ST_DEBOUNCE;
          end else begin
            col_idx_d = col_idx_q + 2'd1;
          end
        end
        ST_DEBOUNCE: begin
          if (pressed && low_row == row_q) begin
            if (cnt_inc >= DB_SCANS) begin
              code_d  = KEYMAP[{row_q, col_idx_q}];
              valid_d = 1'b1;
              cnt_d   = 4'd0;
              state_d = ST_HELD;
            end else begin
              cnt_d = cnt_inc[3:0];
            end
          end else begin
            state_d = ST_SCAN;
          end
        end
        ST_HELD: begin
          if (!pressed) begin
            cnt_d   = 4'd1;
            state_d = ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          // Any row activity restarts the quiet count rather than re-accepting.
          if (pressed) begin
            cnt_d = 4'd0;
          end else if (cnt_inc >= DB_SCANS) begin
            cnt_d   = 4'd0;
            state_d = ST_SCAN;
          end else begin
            cnt_d = cnt_inc[3:0];
          end
        end
        default: state_d = ST_SCAN;
      endcase
    end
  end

  assign key_col   = enable ? ~(4'b0001 << col_idx_q) : 4'hF;
  assign key_code  = code_q;
  assign key_valid = valid_q;
  assign key_held  = enable & ((state_q == ST_HELD) | (state_q == ST_RELEASE));

`ifdef KEYPAD_BCD_ACCUM_EN
  logic [3:0] bcd2_q, bcd1_q, bcd0_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bcd2_q <= 4'd0;
      bcd1_q <= 4'd0;
      bcd0_q <= 4'd0;
    end else if (valid_d) begin
      if (code_d <= 4'd9) begin
        bcd2_q <= bcd1_q;
        bcd1_q <= bcd0_q;
        bcd0_q <= code_d;
      end else if (code_d == KEY_STAR) begin
        bcd2_q <= 4'd0;
        bcd1_q <= 4'd0;
        bcd0_q <= 4'd0;
      end
    end
  end

  assign bcd2 = bcd2_q;
  assign bcd1 = bcd1_q;
  assign bcd0 = bcd0_q;
`endif

endmodule

// File: tb/tb_keypad_scan.sv
// tb/tb_keypad_scan.sv - scoreboard bench for keypad_scan with a switch-matrix model
// Reference model predicts accepted keys per scan tick; a monitor checks outputs each clk.
module tb_keypad_scan;

  localparam int DB = 4;
  localparam int TICK_PERIOD = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b1;
  logic [3:0]  key_row;
  logic [3:0]  key_col, key_code;
  logic        key_valid, key_held;
  logic [15:0] keys = 16'h0;
`ifdef KEYPAD_BCD_ACCUM_EN
  logic [3:0]  bcd2, bcd1, bcd0;
`endif

  int n_cmp = 0;
  int n_fail = 0;
  bit mon_en = 1'b0;

  keypad_scan #(.SCAN_DIV(4), .DEBOUNCE_SCANS(DB)) dut (
    .clk       (clk),
    .reset     (rst_n),
    .enable    (enable),
    .key_row   (key_row),
    .key_col   (key_col),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_held  (key_held)
`ifdef KEYPAD_BCD_ACCUM_EN
    ,
    .bcd2      (bcd2),
    .bcd1      (bcd1),
    .bcd0      (bcd0)
`endif
  );

  always #5 clk = ~clk;

  // Physical matrix: a closed switch pulls its row low only while its column is driven low.
  always_comb begin
    key_row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !key_col[c]) key_row[r] = 1'b0;
  end

  // ---------------- reference model ----------------
  int keymap [16] = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 14, 0, 15, 13};
  int exp_q [$];
  int m_clks = 0;
  logic [3:0] m_h1 = 4'hF, m_h2 = 4'hF;
  int m_col = 0;
  int m_cand = -1;
  int m_stable = 0;
  bit m_down = 1'b0;
  bit m_rel = 1'b0;
  int m_quiet = 0;
  int m_code = 0;
  int m_bcd [3] = '{0, 0, 0};

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_clks = 0; m_h1 = 4'hF; m_h2 = 4'hF; m_col = 0; m_cand = -1; m_stable = 0;
      m_down = 1'b0; m_rel = 1'b0; m_quiet = 0; m_code = 0;
      m_bcd = '{0, 0, 0};
      exp_q.delete();
    end else begin
      bit   tick;
      logic [3:0] sample;
      int   seen;
      tick   = (m_clks % TICK_PERIOD) == TICK_PERIOD - 1;
      m_clks++;
      sample = m_h2;
      m_h2   = m_h1;
      m_h1   = key_row;
      seen = -1;
      for (int r = 3; r >= 0; r--) if (!sample[r]) seen = r;
      if (!enable) begin
        m_cand = -1; m_down = 1'b0; m_rel = 1'b0;
      end else if (tick) begin
        if (!m_down && m_cand < 0) begin
          if (seen >= 0) begin m_cand = seen; m_stable = 1; end
          else m_col = (m_col + 1) % 4;
        end else if (!m_down) begin
          if (seen == m_cand) begin
            m_stable++;
            if (m_stable >= DB) begin
              m_code = keymap[m_cand*4 + m_col];
              exp_q.push_back(m_code);
              if (m_code <= 9) begin
                m_bcd[2] = m_bcd[1]; m_bcd[1] = m_bcd[0]; m_bcd[0] = m_code;
              end else if (m_code == 14) begin
                m_bcd = '{0, 0, 0};
              end
              m_down = 1'b1; m_rel = 1'b0;
            end
          end else begin
            m_cand = -1;
          end
        end else if (!m_rel) begin
          if (seen < 0) begin m_rel = 1'b1; m_quiet = 1; end
        end else begin
          if (seen >= 0) m_quiet = 0;
          else begin
            m_quiet++;
            if (m_quiet >= DB) begin m_down = 1'b0; m_rel = 1'b0; m_cand = -1; end
          end
        end
      end
    end
  end

  // ---------------- checking ----------------
  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      check("key_col", int'(key_col), enable ? int'(~(4'b0001 << m_col) & 4'hF) : 15);
      check("key_held", int'(key_held), int'(enable & m_down));
      check("key_code", int'(key_code), m_code);
`ifdef KEYPAD_BCD_ACCUM_EN
      check("bcd2", int'(bcd2), m_bcd[2]);
      check("bcd1", int'(bcd1), m_bcd[1]);
      check("bcd0", int'(bcd0), m_bcd[0]);
`endif
      if (key_valid) begin
        if (exp_q.size() == 0) check("unexpected_key_valid", 1, 0);
        else check("valid_code", int'(key_code), exp_q.pop_front());
      end
    end
  end

  task automatic wait_held(input bit want, input int budget, input string name);
    bit ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (key_held == want) begin ok = 1'b1; break; end
    end
    check(name, int'(ok), 1);
    #1;
  endtask

  task automatic tap(input int idx);
    keys = 16'h0; keys[idx] = 1'b1;
    wait_held(1'b1, 400, "press_timeout");
    repeat (20) @(negedge clk);
    #1 keys = 16'h0;
    wait_held(1'b0, 400, "release_timeout");
  endtask

  task automatic wait_col(input logic [3:0] col);
    bit ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (key_col == col) begin ok = 1'b1; break; end
    end
    check("col_timeout", int'(ok), 1);
    #1;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    mon_en = 1'b1;
    #1;
    check("rst_key_col", int'(key_col), 14);
    check("rst_key_code", int'(key_code), 0);
    check("rst_key_valid", int'(key_valid), 0);
    check("rst_key_held", int'(key_held), 0);
    @(negedge clk); #1 rst_n = 1'b1;

    // idle scanning
    repeat (90) @(negedge clk);
    #1;
    // steady press r2/c1 ('8')
    tap(9);
    repeat (40) @(negedge clk);
    #1;
    // short bounce on r0/c0
    wait_col(4'b1110);
    keys[0] = 1'b1;
    repeat (30) @(negedge clk);
    #1 keys = 16'h0;
    repeat (80) @(negedge clk);
    #1;
    // bounce during release of '6'
    keys[6] = 1'b1;
    wait_held(1'b1, 400, "press_timeout");
    keys = 16'h0;
    repeat (20) @(negedge clk);
    #1 keys[6] = 1'b1;
    repeat (20) @(negedge clk);
    #1 keys = 16'h0;
    wait_held(1'b0, 600, "release_timeout");
    // enable dropped during debounce of '5'
    keys[5] = 1'b1;
    wait_col(4'b1101);
    repeat (30) @(negedge clk);
    #1 enable = 1'b0;
    repeat (50) @(negedge clk);
    #1 enable = 1'b1;
    wait_held(1'b1, 400, "press_timeout");
    check("reenable_code", int'(key_code), 5);
    keys = 16'h0;
    wait_held(1'b0, 400, "release_timeout");
    // entry 3,2,1 then '*'
    tap(2); tap(1); tap(0);
`ifdef KEYPAD_BCD_ACCUM_EN
    check("bcd_321_d2", int'(bcd2), 3);
    check("bcd_321_d1", int'(bcd1), 2);
    check("bcd_321_d0", int'(bcd0), 1);
`endif
    tap(12);
`ifdef KEYPAD_BCD_ACCUM_EN
    check("bcd_star_d2", int'(bcd2), 0);
    check("bcd_star_d0", int'(bcd0), 0);
`endif
    // reset while '4' is held
    keys[4] = 1'b1;
    wait_held(1'b1, 400, "press_timeout");
    @(negedge clk); #2 rst_n = 1'b0;
    #1;
    check("midrst_key_col", int'(key_col), 14);
    check("midrst_key_code", int'(key_code), 0);
    check("midrst_key_held", int'(key_held), 0);
    check("midrst_key_valid", int'(key_valid), 0);
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
    wait_held(1'b1, 400, "repress_timeout");
    check("repress_code", int'(key_code), 4);
    keys = 16'h0;
    wait_held(1'b0, 400, "release_timeout");

    // randomized presses, double keys and enable glitches
    for (int it = 0; it < 40; it++) begin
      int dur;
      keys = 16'h0;
      keys[$urandom_range(0, 15)] = 1'b1;
      if ($urandom_range(0, 3) == 0) keys[$urandom_range(0, 15)] = 1'b1;
      dur = $urandom_range(5, 160);
      for (int i = 0; i < dur; i++) begin
        @(negedge clk); #1;
        if ($urandom_range(0, 199) == 0) enable = ~enable;
      end
      enable = 1'b1;
      keys = 16'h0;
      repeat ($urandom_range(0, 120)) @(negedge clk);
      #1;
    end

    repeat (200) @(negedge clk);
    check("pending_expectations", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
